rd_ctrl: RTL and testbench
==========================

# rd_ctrl

- Read-side controller of the cache, sibling of the write controller; shares the access (tag/state) port, fetch unit and line data memory.
- Accepts one core read at a time and looks up the line.
- On a miss, writes back a dirty victim and fills the line through the fetch unit, then reads the word from line memory and returns it on a valid/ready response channel.
- Publishes its in-flight line address so the write controller can detect collisions.

## Interface
- addr_width, 32, word address width
- data_width, 32, word width
- list_depth, 4, number of cache lines (slots); slot id width SW = $clog2(list_depth)
- list_width, 32, words per line; offset width OW = $clog2(list_width); line address width LW = addr_width - OW
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- rd_valid / rd_ready  in / out  1  read request handshake
- rd_addr  in  addr_width  word address
- rd_resp_valid / rd_resp_ready  out / in  1  response handshake
- rd_resp_data  out  data_width  read word
- acc_req  out  1  access-port request
- acc_cmd  out  2  00 lookup, 01 mark slot valid-clean after fill
- acc_index  out  LW  line address = rd_addr[addr_width-1:OW]
- acc_tag  out  SW  slot for cmd 01
- acc_status  in  3  [2] ack, [1] victim dirty, [0] hit; valid when [2]=1
- return_tag  in  SW  hit slot or victim slot; valid with ack
- proc_status  out  2  00 idle, 01 lookup/read, 10 miss service
- proc_addr  out  addr_width  latched rd_addr
- fetch_req  out  1  fetch request
- fetch_cmd  out  2  01 fill, 10 writeback
- fetch_tag  out  SW  target slot
- fetch_addr  out  addr_width  line base {line addr, OW'b0}
- fetch_gnt / fetch_done  in  1  fetch accepted / transaction complete pulse
- mem_raddr  out  SW+OW  {slot, word offset}
- mem_ren  out  1  line-memory read strobe
- mem_rvalid  in  1  mem_rdata valid
- mem_rdata  in  data_width  read data

## Operation
- States: IDLE, LOOKUP, WB, FILL, UPDATE, READ, WAIT_RD, RESP.
- IDLE: rd_ready=1; on rd_valid latch rd_addr -> LOOKUP. rd_ready=0 in every other state.
- LOOKUP: acc_req=1, acc_cmd=00 until acc_status[2]. On ack, latch slot=return_tag.
  - hit -> READ
  - miss and dirty -> WB
  - miss and clean -> FILL
- WB: fetch_req=1, fetch_cmd=10, fetch_tag=slot until fetch_gnt; drop fetch_req after gnt; wait fetch_done -> FILL.
- FILL: same handshake, fetch_cmd=01; on fetch_done -> UPDATE.
- UPDATE: acc_req=1, acc_cmd=01, acc_tag=slot until ack -> READ.
- READ: mem_ren=1 for exactly one cycle, mem_raddr={slot, addr[OW-1:0]} -> WAIT_RD.
- WAIT_RD: on mem_rvalid capture mem_rdata -> RESP.
- RESP: rd_resp_valid=1, data stable until rd_resp_ready -> IDLE.
- proc_status: 01 in LOOKUP/READ/WAIT_RD/RESP; 10 in WB/FILL/UPDATE; 00 in IDLE.
- fetch_done before fetch_gnt, or outside WB/FILL: ignored.
- mem_rvalid outside WAIT_RD: ignored.
- acc_status ignored unless acc_req=1.

## Timing
- All outputs reset to 0; state=IDLE. rd_ready rises the cycle after rst_n releases.
- Reset mid-operation: abandon the transaction; no response issued. Access port and fetch unit are reset together with this block.
- Ack, fetch_gnt and mem_rvalid are sampled in the cycle they are high. acc_req/fetch_req deassert the following cycle.
- Hit path, zero-wait ack and 1-cycle memory:
  - accept at T; LOOKUP T+1; mem_ren T+2; mem_rvalid T+3; rd_resp_valid T+4.
- Back-to-back: a response accepted at cycle R allows a new accept at R+1.
- Miss adds WB (if dirty) + FILL + UPDATE cycles; each fetch phase is at least 2 cycles (gnt, done).
- rd_resp_valid never drops without rd_resp_ready.

## Configuration
- RD_CTRL_PERF_CNT_EN defined:
  - adds outputs hit_cnt and miss_cnt, 32 bits each.
  - Each increments once per ack in LOOKUP; saturates at 0xFFFFFFFF; reset 0.
- RD_CTRL_PERF_CNT_EN undefined: ports and logic absent; behaviour otherwise identical.

## Test plan
- Hit: rd_addr=0x0000_0045 (list_width=32); ack with status=3'b101, return_tag=2 -> mem_raddr={2,5'd5}=0x45; mem_rdata=0xDEADBEEF -> rd_resp_data=0xDEADBEEF at T+4.
- Clean miss: status=3'b100, return_tag=1 -> fetch_cmd=01, fetch_tag=1, fetch_addr=0x40; then acc_cmd=01, acc_tag=1; then word returned. No WB issued.
- Dirty miss: status=3'b110, return_tag=3 -> WB fetch_cmd=10 precedes FILL 01; fetch_gnt delayed 3 cycles -> fetch_req held high all 3.
- Back-pressure: rd_resp_ready low 5 cycles -> rd_resp_valid and data stable; rd_ready=0 throughout; accept next request the cycle after ready.
- Reset in FILL with rst_n low 1 cycle -> all outputs 0 next edge; no response; rd_ready=1 after release.
- With RD_CTRL_PERF_CNT_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rd_ctrl_if
//  Description : Bundle of every handshake and bus signal seen by the cache
//                read controller: core request/response, access (tag/state)
//                port, fetch unit and line data memory read port.
//  Revision    : 1.0  initial release
// ============================================================================
interface rd_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32
);
  localparam int c_sw = $clog2(LIST_DEPTH);
  localparam int c_ow = $clog2(LIST_WIDTH);
  localparam int c_lw = ADDR_WIDTH - c_ow;

  // core read request
  logic                   rd_valid;
  logic                   rd_ready;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  // core read response
  logic                   rd_resp_valid;
  logic                   rd_resp_ready;
  logic [DATA_WIDTH-1:0]  rd_resp_data;
  // access (tag/state) port
  logic                   acc_req;
  logic [1:0]             acc_cmd;
  logic [c_lw-1:0]        acc_index;
  logic [c_sw-1:0]        acc_tag;
  logic [2:0]             acc_status;
  logic [c_sw-1:0]        return_tag;
  // in-flight line publication
  logic [1:0]             proc_status;
  logic [ADDR_WIDTH-1:0]  proc_addr;
  // fetch unit
  logic                   fetch_req;
  logic [1:0]             fetch_cmd;
  logic [c_sw-1:0]        fetch_tag;
  logic [ADDR_WIDTH-1:0]  fetch_addr;
  logic                   fetch_gnt;
  logic                   fetch_done;
  // line data memory
  logic [c_sw+c_ow-1:0]   mem_raddr;
  logic                   mem_ren;
  logic                   mem_rvalid;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  // controller side
  modport master (
    input  rd_valid, rd_addr, rd_resp_ready,
    input  acc_status, return_tag,
    input  fetch_gnt, fetch_done,
    input  mem_rvalid, mem_rdata,
    output rd_ready, rd_resp_valid, rd_resp_data,
    output acc_req, acc_cmd, acc_index, acc_tag,
    output proc_status, proc_addr,
    output fetch_req, fetch_cmd, fetch_tag, fetch_addr,
    output mem_raddr, mem_ren
  );

  // environment side (core, access port, fetch unit, line memory)
  modport slave (
    output rd_valid, rd_addr, rd_resp_ready,
    output acc_status, return_tag,
    output fetch_gnt, fetch_done,
    output mem_rvalid, mem_rdata,
    input  rd_ready, rd_resp_valid, rd_resp_data,
    input  acc_req, acc_cmd, acc_index, acc_tag,
    input  proc_status, proc_addr,
    input  fetch_req, fetch_cmd, fetch_tag, fetch_addr,
    input  mem_raddr, mem_ren
  );
endinterface : rd_ctrl_if
`default_nettype wire

// File: rtl/rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rd_ctrl
//  Description : Cache read-side controller. Accepts one core read at a time,
//                looks the line up through the access port, services misses
//                (dirty-victim writeback then fill via the fetch unit, then
//                marks the slot valid-clean), reads the word from line memory
//                and returns it on a valid/ready response channel. The
//                in-flight address is published for collision detection by
//                the write controller.
//                Optional feature macro: RD_CTRL_PERF_CNT_EN adds saturating
//                32-bit hit_cnt / miss_cnt outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RD_CTRL_PERF_CNT_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
`endif
  rd_ctrl_if.master         bus
);

  localparam int c_sw = $clog2(LIST_DEPTH);
  localparam int c_ow = $clog2(LIST_WIDTH);
  localparam int c_lw = ADDR_WIDTH - c_ow;

  localparam logic [1:0] c_acc_lookup = 2'b00;
  localparam logic [1:0] c_acc_mark   = 2'b01;
  localparam logic [1:0] c_fetch_fill = 2'b01;
  localparam logic [1:0] c_fetch_wb   = 2'b10;
  localparam logic [1:0] c_ps_idle    = 2'b00;
  localparam logic [1:0] c_ps_read    = 2'b01;
  localparam logic [1:0] c_ps_miss    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_WB      = 3'd2,
    S_FILL    = 3'd3,
    S_UPDATE  = 3'd4,
    S_READ    = 3'd5,
    S_WAIT_RD = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  state_t                  r_state;
  logic                    r_rd_ready;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_data;
  logic                    r_acc_req;
  logic [1:0]              r_acc_cmd;
  logic [c_lw-1:0]         r_acc_index;
  logic [c_sw-1:0]         r_acc_tag;
  logic [1:0]              r_proc_status;
  logic [ADDR_WIDTH-1:0]   r_proc_addr;
  logic                    r_fetch_req;
  logic [1:0]              r_fetch_cmd;
  logic [c_sw-1:0]         r_fetch_tag;
  logic [ADDR_WIDTH-1:0]   r_fetch_addr;
  logic [c_sw+c_ow-1:0]    r_mem_raddr;
  logic                    r_mem_ren;
  logic [c_sw-1:0]         r_slot;      // hit slot or victim slot from lookup
  logic                    r_gnt_seen;  // fetch accepted, now waiting for done

  // The access port answer only counts while we are actually requesting.
  logic w_acc_ack;
  logic w_lookup_ack;
  assign w_acc_ack    = r_acc_req & bus.acc_status[2];
  assign w_lookup_ack = (r_state == S_LOOKUP) & w_acc_ack;

  // Every output is a register; drive the bus straight from them.
  assign bus.rd_ready      = r_rd_ready;
  assign bus.rd_resp_valid = r_resp_valid;
  assign bus.rd_resp_data  = r_resp_data;
  assign bus.acc_req       = r_acc_req;
  assign bus.acc_cmd       = r_acc_cmd;
  assign bus.acc_index     = r_acc_index;
  assign bus.acc_tag       = r_acc_tag;
  assign bus.proc_status   = r_proc_status;
  assign bus.proc_addr     = r_proc_addr;
  assign bus.fetch_req     = r_fetch_req;
  assign bus.fetch_cmd     = r_fetch_cmd;
  assign bus.fetch_tag     = r_fetch_tag;
  assign bus.fetch_addr    = r_fetch_addr;
  assign bus.mem_raddr     = r_mem_raddr;
  assign bus.mem_ren       = r_mem_ren;

  // Transaction sequencer: state and all registered outputs move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rd_ready    <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_acc_req     <= 1'b0;
      r_acc_cmd     <= '0;
      r_acc_index   <= '0;
      r_acc_tag     <= '0;
      r_proc_status <= '0;
      r_proc_addr   <= '0;
      r_fetch_req   <= 1'b0;
      r_fetch_cmd   <= '0;
      r_fetch_tag   <= '0;
      r_fetch_addr  <= '0;
      r_mem_raddr   <= '0;
      r_mem_ren     <= 1'b0;
      r_slot        <= '0;
      r_gnt_seen    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // rd_ready comes up one cycle after reset release and after RESP.
          r_rd_ready <= 1'b1;
          if (r_rd_ready && bus.rd_valid) begin
            r_rd_ready    <= 1'b0;
            r_proc_addr   <= bus.rd_addr;
            r_acc_index   <= bus.rd_addr[ADDR_WIDTH-1:c_ow];
            r_fetch_addr  <= {bus.rd_addr[ADDR_WIDTH-1:c_ow], {c_ow{1'b0}}};
            r_acc_req     <= 1'b1;
            r_acc_cmd     <= c_acc_lookup;
            r_proc_status <= c_ps_read;
            r_state       <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (w_acc_ack) begin
            r_acc_req <= 1'b0;
            r_slot    <= bus.return_tag;
            if (bus.acc_status[0]) begin
              r_mem_ren   <= 1'b1;
              r_mem_raddr <= {bus.return_tag, r_proc_addr[c_ow-1:0]};
              r_state     <= S_READ;
            end else begin
              r_proc_status <= c_ps_miss;
              r_fetch_req   <= 1'b1;
              r_fetch_tag   <= bus.return_tag;
              r_gnt_seen    <= 1'b0;
              if (bus.acc_status[1]) begin
                r_fetch_cmd <= c_fetch_wb;
                r_state     <= S_WB;
              end else begin
                r_fetch_cmd <= c_fetch_fill;
                r_state     <= S_FILL;
              end
            end
          end
        end

        S_WB, S_FILL: begin
          // A done pulse only completes the phase once the grant was taken.
          if (r_fetch_req && bus.fetch_gnt) begin
            r_fetch_req <= 1'b0;
            r_gnt_seen  <= 1'b1;
          end else if (r_gnt_seen && bus.fetch_done) begin
            r_gnt_seen <= 1'b0;
            if (r_state == S_WB) begin
              r_fetch_req <= 1'b1;
              r_fetch_cmd <= c_fetch_fill;
              r_state     <= S_FILL;
            end else begin
              r_acc_req <= 1'b1;
              r_acc_cmd <= c_acc_mark;
              r_acc_tag <= r_slot;
              r_state   <= S_UPDATE;
            end
          end
        end

        S_UPDATE: begin
          if (w_acc_ack) begin
            r_acc_req     <= 1'b0;
            r_mem_ren     <= 1'b1;
            r_mem_raddr   <= {r_slot, r_proc_addr[c_ow-1:0]};
            r_proc_status <= c_ps_read;
            r_state       <= S_READ;
          end
        end

        S_READ: begin
          // Single-cycle read strobe.
          r_mem_ren <= 1'b0;
          r_state   <= S_WAIT_RD;
        end

        S_WAIT_RD: begin
          if (bus.mem_rvalid) begin
            r_resp_data  <= bus.mem_rdata;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          if (bus.rd_resp_ready) begin
            r_resp_valid  <= 1'b0;
            r_rd_ready    <= 1'b1;
            r_proc_status <= c_ps_idle;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RD_CTRL_PERF_CNT_EN
  // Saturating hit/miss counters, one event per lookup acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (w_lookup_ack) begin
      if (bus.acc_status[0]) begin
        if (hit_cnt != 32'hFFFF_FFFF) begin
          hit_cnt <= hit_cnt + 32'd1;
        end
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule : rd_ctrl
`default_nettype wire

// File: tb/tb_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rd_ctrl
//  Description : Self-checking bench for rd_ctrl. The bench plays core,
//                access port, fetch unit and line memory; each read is
//                described at transaction level (hit / clean miss / dirty
//                miss, slot, latencies, data) and the expected output
//                sequence follows from that description.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rd_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LD = 4;
  localparam int LWD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LIST_DEPTH(LD), .LIST_WIDTH(LWD)) bus ();

`ifdef RD_CTRL_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LIST_DEPTH(LD), .LIST_WIDTH(LWD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RD_CTRL_PERF_CNT_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction description: kind 0 hit, 1 clean miss, 2 dirty miss.
  typedef struct {
    int          kind;
    logic [1:0]  tag;
    logic [31:0] addr;
    int          ack_lat;
    int          gnt_lat;
    int          done_lat;
    int          mem_lat;
    int          resp_lat;
    logic [31:0] data;
  } txn_t;

  // Observed values kept for literal cross-checks of directed cases.
  logic [6:0]  obs_raddr;
  logic [31:0] obs_faddr;
  logic [31:0] obs_data;
  int          exp_hits = 0;
  int          exp_misses = 0;

  // Free-running monitor: accept-to-response latency and invariants.
  int   cyc_cnt = 0;
  int   acc_cyc = 0;
  int   last_lat = -1;
  logic prev_rv_p = 1'b0;
  always @(posedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (rst_n && bus.rd_valid && bus.rd_ready) acc_cyc = cyc_cnt;
    if (bus.rd_resp_valid && !prev_rv_p) last_lat = cyc_cnt - acc_cyc;
    prev_rv_p = bus.rd_resp_valid;
  end

  logic        m_prev_rv = 1'b0;
  logic        m_prev_rr = 1'b0;
  logic        m_prev_ren = 1'b0;
  logic        m_prev_rst = 1'b0;
  logic [31:0] m_prev_data = '0;
  always @(negedge clk) begin
    if (m_prev_rst && m_prev_rv && !m_prev_rr) begin
      chk("resp_valid_hold", 64'(bus.rd_resp_valid), 64'(1));
      chk("resp_data_hold", 64'(bus.rd_resp_data), 64'(m_prev_data));
    end
    if (m_prev_rst && m_prev_ren) chk("mem_ren_one_cycle", 64'(bus.mem_ren), 64'(0));
    chk("rd_ready_exclusive",
        64'(bus.rd_ready & (bus.acc_req | bus.fetch_req | bus.mem_ren | bus.rd_resp_valid)), 64'(0));
    m_prev_rv   = bus.rd_resp_valid;
    m_prev_rr   = bus.rd_resp_ready;
    m_prev_ren  = bus.mem_ren;
    m_prev_rst  = rst_n;
    m_prev_data = bus.rd_resp_data;
  end

  task automatic chk_all_zero(input string tagname);
    chk({tagname, "_rd_ready"},   64'(bus.rd_ready), 64'(0));
    chk({tagname, "_resp_valid"}, 64'(bus.rd_resp_valid), 64'(0));
    chk({tagname, "_resp_data"},  64'(bus.rd_resp_data), 64'(0));
    chk({tagname, "_acc_req"},    64'(bus.acc_req), 64'(0));
    chk({tagname, "_acc_cmd"},    64'(bus.acc_cmd), 64'(0));
    chk({tagname, "_acc_index"},  64'(bus.acc_index), 64'(0));
    chk({tagname, "_acc_tag"},    64'(bus.acc_tag), 64'(0));
    chk({tagname, "_proc_status"},64'(bus.proc_status), 64'(0));
    chk({tagname, "_proc_addr"},  64'(bus.proc_addr), 64'(0));
    chk({tagname, "_fetch_req"},  64'(bus.fetch_req), 64'(0));
    chk({tagname, "_fetch_cmd"},  64'(bus.fetch_cmd), 64'(0));
    chk({tagname, "_fetch_tag"},  64'(bus.fetch_tag), 64'(0));
    chk({tagname, "_fetch_addr"}, 64'(bus.fetch_addr), 64'(0));
    chk({tagname, "_mem_raddr"},  64'(bus.mem_raddr), 64'(0));
    chk({tagname, "_mem_ren"},    64'(bus.mem_ren), 64'(0));
`ifdef RD_CTRL_PERF_CNT_EN
    chk({tagname, "_hit_cnt"},    64'(hit_cnt), 64'(0));
    chk({tagname, "_miss_cnt"},   64'(miss_cnt), 64'(0));
`endif
  endtask

  // One access-port transaction; ack after ack_lat waiting cycles.
  task automatic access_phase(input logic [1:0] cmd, input txn_t t, input logic [2:0] status,
                              input logic [1:0] ps);
    for (int i = 0; i <= t.ack_lat; i++) begin
      chk("acc_req", 64'(bus.acc_req), 64'(1));
      chk("acc_cmd", 64'(bus.acc_cmd), 64'(cmd));
      chk("acc_index", 64'(bus.acc_index), 64'(t.addr[31:5]));
      if (cmd == 2'b01) chk("acc_tag", 64'(bus.acc_tag), 64'(t.tag));
      chk("proc_status", 64'(bus.proc_status), 64'(ps));
      chk("proc_addr", 64'(bus.proc_addr), 64'(t.addr));
      chk("fetch_req_in_acc", 64'(bus.fetch_req), 64'(0));
      if (i == t.ack_lat) begin
        bus.acc_status = status;
        bus.return_tag = t.tag;
      end else begin
        bus.acc_status = {1'b0, 2'($urandom)};
        bus.return_tag = 2'($urandom);
      end
      @(negedge clk);
    end
    bus.acc_status = 3'b000;
    chk("acc_req_drop", 64'(bus.acc_req), 64'(0));
  endtask

  // One fetch-unit transaction with a premature done and stray acks thrown in.
  task automatic fetch_phase(input logic [1:0] cmd, input txn_t t);
    for (int i = 0; i <= t.gnt_lat; i++) begin
      chk("fetch_req", 64'(bus.fetch_req), 64'(1));
      chk("fetch_cmd", 64'(bus.fetch_cmd), 64'(cmd));
      chk("fetch_tag", 64'(bus.fetch_tag), 64'(t.tag));
      chk("fetch_addr", 64'(bus.fetch_addr), 64'({t.addr[31:5], 5'd0}));
      chk("proc_status_miss", 64'(bus.proc_status), 64'(2'b10));
      chk("acc_req_in_fetch", 64'(bus.acc_req), 64'(0));
      if (cmd == 2'b01) obs_faddr = bus.fetch_addr;
      bus.fetch_gnt  = (i == t.gnt_lat);
      bus.fetch_done = (i == 0 && t.gnt_lat > 0);
      bus.acc_status = {1'b1, 2'($urandom)};
      @(negedge clk);
    end
    bus.fetch_gnt  = 1'b0;
    bus.fetch_done = 1'b0;
    bus.acc_status = 3'b000;
    for (int i = 0; i <= t.done_lat; i++) begin
      chk("fetch_req_after_gnt", 64'(bus.fetch_req), 64'(0));
      chk("proc_status_miss", 64'(bus.proc_status), 64'(2'b10));
      bus.fetch_done = (i == t.done_lat);
      @(negedge clk);
    end
    bus.fetch_done = 1'b0;
  endtask

  // Full read, entered at a negedge with the controller idle.
  task automatic run_txn(input txn_t t);
    logic [2:0] status;
    status = {1'b1, t.kind == 2, t.kind == 0};
    chk("rd_ready_idle", 64'(bus.rd_ready), 64'(1));
    chk("proc_status_idle", 64'(bus.proc_status), 64'(0));
    bus.rd_valid = 1'b1;
    bus.rd_addr  = t.addr;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    bus.rd_addr  = $urandom;
    chk("rd_ready_busy", 64'(bus.rd_ready), 64'(0));
    access_phase(2'b00, t, status, 2'b01);
    if (t.kind == 0) exp_hits++;
    else exp_misses++;
    if (t.kind == 2) fetch_phase(2'b10, t);
    if (t.kind != 0) begin
      fetch_phase(2'b01, t);
      access_phase(2'b01, t, 3'b100, 2'b10);
    end
    chk("mem_ren", 64'(bus.mem_ren), 64'(1));
    chk("mem_raddr", 64'(bus.mem_raddr), 64'({t.tag, t.addr[4:0]}));
    chk("proc_status_read", 64'(bus.proc_status), 64'(2'b01));
    obs_raddr = bus.mem_raddr;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = ~t.data;
    @(negedge clk);
    for (int i = 1; i <= t.mem_lat; i++) begin
      chk("mem_ren_low", 64'(bus.mem_ren), 64'(0));
      chk("resp_valid_early", 64'(bus.rd_resp_valid), 64'(0));
      bus.mem_rvalid = (i == t.mem_lat);
      bus.mem_rdata  = (i == t.mem_lat) ? t.data : $urandom;
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
    for (int i = 0; i <= t.resp_lat; i++) begin
      chk("resp_valid", 64'(bus.rd_resp_valid), 64'(1));
      chk("resp_data", 64'(bus.rd_resp_data), 64'(t.data));
      chk("rd_ready_in_resp", 64'(bus.rd_ready), 64'(0));
      chk("proc_status_resp", 64'(bus.proc_status), 64'(2'b01));
      obs_data = bus.rd_resp_data;
      bus.rd_resp_ready = (i == t.resp_lat);
      @(negedge clk);
    end
    bus.rd_resp_ready = 1'b0;
    chk("resp_valid_done", 64'(bus.rd_resp_valid), 64'(0));
  endtask

  function automatic txn_t mk(input int kind, input logic [1:0] tag, input logic [31:0] addr,
                              input int gnt_lat, input int resp_lat, input logic [31:0] data);
    txn_t t;
    t.kind = kind; t.tag = tag; t.addr = addr;
    t.ack_lat = 0; t.gnt_lat = gnt_lat; t.done_lat = 0;
    t.mem_lat = 1; t.resp_lat = resp_lat; t.data = data;
    return t;
  endfunction

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    txn_t t;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rd_resp_ready = 1'b0;
    bus.acc_status = '0; bus.return_tag = '0;
    bus.fetch_gnt = 1'b0; bus.fetch_done = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rd_ready_after_reset", 64'(bus.rd_ready), 64'(1));

    // Hit, zero-wait: literal pins on raddr, data and latency.
    run_txn(mk(0, 2'd2, 32'h0000_0045, 0, 0, 32'hDEAD_BEEF));
    chk("hit_mem_raddr_lit", 64'(obs_raddr), 64'(7'h45));
    chk("hit_resp_data_lit", 64'(obs_data), 64'(32'hDEAD_BEEF));
    chk("hit_latency_lit", 64'(last_lat), 64'(4));

    // Clean miss, slot 1: fill at line base 0x40.
    run_txn(mk(1, 2'd1, 32'h0000_004A, 0, 0, 32'h1234_5678));
    chk("clean_fetch_addr_lit", 64'(obs_faddr), 64'(32'h0000_0040));
    chk("clean_resp_data_lit", 64'(obs_data), 64'(32'h1234_5678));

    // Dirty miss, slot 3, grant held off 3 cycles.
    run_txn(mk(2, 2'd3, 32'h0000_1F83, 3, 0, 32'hCAFE_F00D));
    // Back-pressure: response ready held low 5 cycles, then back-to-back hit.
    run_txn(mk(0, 2'd0, 32'h0000_0100, 0, 5, 32'h0BAD_CAFE));
    run_txn(mk(0, 2'd1, 32'hFFFF_FFFF, 0, 0, 32'hA5A5_5A5A));
    chk("boundary_mem_raddr_lit", 64'(obs_raddr), 64'(7'h3F));
`ifdef RD_CTRL_PERF_CNT_EN
    chk("hit_cnt_lit", 64'(hit_cnt), 64'(3));
    chk("miss_cnt_lit", 64'(miss_cnt), 64'(2));
`endif

    // Reset while in FILL: transaction abandoned, no response.
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 32'h0000_0220;
    @(negedge clk);
    bus.rd_valid   = 1'b0;
    bus.acc_status = 3'b100;
    bus.return_tag = 2'd1;
    @(negedge clk);
    bus.acc_status = 3'b000;
    chk("rst_fill_fetch_req", 64'(bus.fetch_req), 64'(1));
    chk("rst_fill_fetch_cmd", 64'(bus.fetch_cmd), 64'(2'b01));
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rd_ready_after_midreset", 64'(bus.rd_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("no_resp_after_reset", 64'(bus.rd_resp_valid), 64'(0));
      @(negedge clk);
    end
    exp_hits = 0;
    exp_misses = 0;

    // Randomized reads.
    for (int n = 0; n < 40; n++) begin
      t.kind     = int'($urandom_range(0, 2));
      t.tag      = 2'($urandom);
      t.addr     = $urandom;
      t.ack_lat  = int'($urandom_range(0, 2));
      t.gnt_lat  = int'($urandom_range(0, 3));
      t.done_lat = int'($urandom_range(0, 2));
      t.mem_lat  = int'($urandom_range(1, 3));
      t.resp_lat = int'($urandom_range(0, 3));
      t.data     = $urandom;
      run_txn(t);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
`ifdef RD_CTRL_PERF_CNT_EN
    chk("hit_cnt_model", 64'(hit_cnt), 64'(exp_hits));
    chk("miss_cnt_model", 64'(miss_cnt), 64'(exp_misses));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule : tb_rd_ctrl
`default_nettype wire
